pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage MIPS pipeline. It drives the
//  enable and flush/bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//  It resolves load-use hazards, taken-branch squashes and multi-cycle data
//  memory waits, with a timeout watchdog and a stall performance counter.
// PARAMETERS
//  MEM_TIMEOUT  255  max MEM_WAIT cycles before entering ERROR (1..65535)
//  CNT_W        16   width of o_stall_cnt
// PORTS
//  clk            in   1      clock, rising edge
//  nrst           in   1      asynchronous active-low reset
//  i_ID_rs        in   5      rs field of instruction in ID
//  i_ID_rt        in   5      rt field of instruction in ID
//  i_ID_useRt     in   1      ID instruction reads rt
//  i_EX_MemRead   in   1      instruction in EX is a load
//  i_EX_RegAddrW  in   5      destination register of EX instruction
//  i_EX_BrTaken   in   1      branch/jump in EX resolved taken
//  i_MEM_req      in   1      MEM stage issues a data-memory access
//  i_MEM_ack      in   1      data memory completes access this cycle
//  o_PC_en        out  1      PC update enable
//  o_IFID_en      out  1      IF/ID register enable
//  o_IFID_flush   out  1      IF/ID load NOP
//  o_IDEX_en      out  1      ID/EX register enable
//  o_IDEX_flush   out  1      ID/EX load bubble (all ctrl bits 0)
//  o_EXMEM_en     out  1      EX/MEM register enable
//  o_MEMWB_en     out  1      MEM/WB register enable
//  o_MEMWB_bubble out  1      force RegWrite=0, Mem2Reg=0 into MEM/WB
//  o_stall_cnt    out  CNT_W  cycles with o_PC_en=0, saturating
//  o_timeout      out  1      sticky watchdog error flag
// BEHAVIOUR
//  FSM states: RUN, MEM_WAIT, ERROR. Reset -> RUN, wait_cnt=0, stall_cnt=0,
//   o_timeout=0. While nrst=0 all *_en=0, all flush/bubble=1.
//  Outputs are combinational from state and inputs (zero latency). Counters
//   and flags are registered.
//  Base ("advance") outputs: all *_en=1; flush/bubble=0.
//  Load-use: i_EX_MemRead & i_EX_RegAddrW!=0 & (==i_ID_rs | (i_ID_useRt &
//   ==i_ID_rt)). Result: PC_en=0, IFID_en=0, IDEX_flush=1; others advance.
//   The hazard lasts one cycle because the load then leaves EX.
//  Branch: i_EX_BrTaken -> IFID_flush=1, IDEX_flush=1; all enables 1.
//   Branch overrides load-use in the same cycle (the ID instruction is squashed).
//  RUN: if i_MEM_req & ~i_MEM_ack, go to MEM_WAIT. In that cycle PC/IFID/IDEX/
//   EXMEM_en=0, MEMWB_en=1 with MEMWB_bubble=1, and flushes=0. Otherwise apply
//   branch, then load-use, then advance.
//  MEM_WAIT, ~ack: same freeze as above; wait_cnt++. If wait_cnt reaches
//   MEM_TIMEOUT-1, go to ERROR and set o_timeout=1.
//  MEM_WAIT, ack: evaluate exactly as RUN with ack=1 (pipeline advances;
//   branch and load-use rules apply). Go to RUN and set wait_cnt=0.
//  Back-to-back: ack plus a new req in the following cycle re-enters MEM_WAIT
//   normally.
//  ERROR: all *_en=0, MEMWB_bubble=1, flush=0. ERROR is held until nrst.
//  o_stall_cnt: +1 every cycle with o_PC_en=0 and nrst=1. Saturates at
//   all-ones with no wrap.
//  Reset asserted mid-MEM_WAIT: immediate return to RUN. Counters clear.
//   A pending ack is ignored.
//  Register address 0 never creates a hazard.
// TESTING
//  1 Load r5 in EX, ID uses rs=5 -> 1 cycle PC_en=0, IFID_en=0, IDEX_flush=1;
//    stall_cnt=1.
//  2 Same with RegAddrW=0, or rt=5 with useRt=0 -> no stall, all en=1.
//  3 BrTaken=1 together with the load-use hazard -> IFID_flush=IDEX_flush=1,
//    PC_en=1, no stall.
//  4 req=1, ack arrives after 3 cycles -> 3 freeze cycles with MEMWB_bubble=1,
//    advance on the ack cycle, stall_cnt=3.
//  5 MEM_TIMEOUT=4, req held with ack=0 -> ERROR after 4 wait cycles;
//    o_timeout=1 and sticky.
//  6 nrst pulsed low in cycle 2 of MEM_WAIT -> RUN; stall_cnt=0;
//    a later req/ack works normally.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//  Stall/flush scheduler for the 5-stage pipeline. It resolves load-use
//  hazards, taken-branch squashes and multi-cycle data-memory waits, with a
//  sticky watchdog for memory that never answers and a saturating stall counter.
// Ports
//  clk, nrst                     clock (rising edge), async active-low reset
//  i_ID_rs/i_ID_rt/i_ID_useRt    source operands of the instruction in ID
//  i_EX_MemRead/i_EX_RegAddrW    load flag and destination of the instruction in EX
//  i_EX_BrTaken                  taken branch/jump resolved in EX
//  i_MEM_req/i_MEM_ack           data-memory handshake from MEM
//  o_*_en, o_*_flush, o_MEMWB_bubble  pipeline register controls (combinational)
//  o_stall_cnt                   cycles with o_PC_en=0, saturating (registered)
//  o_timeout                     sticky watchdog flag (registered)
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [4:0]       i_ID_rs,
  input  logic [4:0]       i_ID_rt,
  input  logic             i_ID_useRt,
  input  logic             i_EX_MemRead,
  input  logic [4:0]       i_EX_RegAddrW,
  input  logic             i_EX_BrTaken,
  input  logic             i_MEM_req,
  input  logic             i_MEM_ack,
  output logic             o_PC_en,
  output logic             o_IFID_en,
  output logic             o_IFID_flush,
  output logic             o_IDEX_en,
  output logic             o_IDEX_flush,
  output logic             o_EXMEM_en,
  output logic             o_MEMWB_en,
  output logic             o_MEMWB_bubble,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic             o_timeout
);

  // wait_cnt only has to reach MEM_TIMEOUT-1
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                timeout_q, timeout_d;

  logic load_use;
  logic mem_stall;

  // Register 0 is hard-wired, so a load targeting it never blocks ID
  assign load_use = i_EX_MemRead && (i_EX_RegAddrW != 5'd0) &&
                    ((i_EX_RegAddrW == i_ID_rs) ||
                     (i_ID_useRt && (i_EX_RegAddrW == i_ID_rt)));

  // Memory freeze: a fresh unacknowledged request in RUN, or any cycle of
  // MEM_WAIT without ack (req is not re-qualified while waiting)
  assign mem_stall = ((state_q == RUN) && i_MEM_req && !i_MEM_ack) ||
                     ((state_q == MEM_WAIT) && !i_MEM_ack);

  // Pipeline controls; priority: reset, error, memory freeze, branch, load-use
  always_comb begin
    o_PC_en        = 1'b1;
    o_IFID_en      = 1'b1;
    o_IFID_flush   = 1'b0;
    o_IDEX_en      = 1'b1;
    o_IDEX_flush   = 1'b0;
    o_EXMEM_en     = 1'b1;
    o_MEMWB_en     = 1'b1;
    o_MEMWB_bubble = 1'b0;
    if (!nrst) begin
      o_PC_en        = 1'b0;
      o_IFID_en      = 1'b0;
      o_IFID_flush   = 1'b1;
      o_IDEX_en      = 1'b0;
      o_IDEX_flush   = 1'b1;
      o_EXMEM_en     = 1'b0;
      o_MEMWB_en     = 1'b0;
      o_MEMWB_bubble = 1'b1;
    end else if (state_q == ERROR) begin
      o_PC_en        = 1'b0;
      o_IFID_en      = 1'b0;
      o_IDEX_en      = 1'b0;
      o_EXMEM_en     = 1'b0;
      o_MEMWB_en     = 1'b0;
      o_MEMWB_bubble = 1'b1;
    end else if (mem_stall) begin
      // MEM/WB keeps clocking so the stalled access does not write back twice
      o_PC_en        = 1'b0;
      o_IFID_en      = 1'b0;
      o_IDEX_en      = 1'b0;
      o_EXMEM_en     = 1'b0;
      o_MEMWB_bubble = 1'b1;
    end else if (i_EX_BrTaken) begin
      // Squashes the ID instruction, which also cancels any load-use stall
      o_IFID_flush   = 1'b1;
      o_IDEX_flush   = 1'b1;
    end else if (load_use) begin
      o_PC_en        = 1'b0;
      o_IFID_en      = 1'b0;
      o_IDEX_flush   = 1'b1;
    end
  end

  // Next state, watchdog and stall counter
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    if (!o_PC_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      RUN: begin
        if (i_MEM_req && !i_MEM_ack) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (i_MEM_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d    = ERROR;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_timeout   = timeout_q;

endmodule
